// File: rtl/count_tick_pkg.sv
// Shared types and helpers for the counter tick controller.
// FSM state encoding, synchroniser depth and prescaler width helper.
package count_tick_pkg;

   typedef enum logic {
      PAUSED  = 1'b0,
      RUNNING = 1'b1
   } state_t;

   localparam int SYNC_STAGES = 2;

   function automatic int div_cnt_width(input int div);
      return (div > 2) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability debouncer, rising-edge press pulse.
// Raw edge to press pulse is SYNC_STAGES + DEB_CYCLES + 1 cycles; glitches shorter than DEB_CYCLES are dropped.
module btn_debounce
   import count_tick_pkg::*;
#(
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [CW-1:0]          cnt;
   logic                   level_q;
   logic                   synced;

   assign synced = sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         sync    <= '0;
         cnt     <= '0;
         level   <= 1'b0;
         level_q <= 1'b0;
         press   <= 1'b0;
      end else begin
         sync    <= {sync[SYNC_STAGES-2:0], btn_raw};
         level_q <= level;
         press   <= level & ~level_q;
         // Any sample agreeing with the accepted level restarts the stability window.
         if (synced == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEB_CYCLES - 1)) begin
            level <= synced;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/count_tick_ctrl.sv
// Run/pause and single-step tick generator feeding the T-flip-flop counter's LSB enable.
// tick is a registered 1-cycle pulse: DIV-periodic while RUNNING, one per step press while PAUSED.
module count_tick_ctrl
   import count_tick_pkg::*;
#(
   parameter int DIV        = 50_000_000,
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_run,
   input  logic btn_step,
   output logic tick,
   output logic running
);

   localparam int DW = div_cnt_width(DIV);

   logic [1:0]    unused_levels;
   logic          run_press;
   logic          step_press;
   state_t        state;
   state_t        state_nxt;
   logic [DW-1:0] div_cnt;
   logic [DW-1:0] div_nxt;
   logic          tick_nxt;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run_btn (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_run),
      .level   (unused_levels[0]),
      .press   (run_press)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_btn (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_step),
      .level   (unused_levels[1]),
      .press   (step_press)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= PAUSED;
         div_cnt <= '0;
         tick    <= 1'b0;
         running <= 1'b0;
      end else begin
         state   <= state_nxt;
         div_cnt <= div_nxt;
         tick    <= tick_nxt;
         running <= (state_nxt == RUNNING);
      end
   end

   // div_cnt defaults to 0 so every pause/run transition restarts the prescaler phase.
   always_comb begin
      state_nxt = state;
      div_nxt   = '0;
      tick_nxt  = 1'b0;
      unique case (state)
         PAUSED: begin
            if (run_press) begin
               state_nxt = RUNNING;
            end else begin
               tick_nxt = step_press;
            end
         end
         RUNNING: begin
            if (run_press) begin
               state_nxt = PAUSED;
            end else if (div_cnt == DW'(DIV - 1)) begin
               tick_nxt = 1'b1;
            end else begin
               div_nxt = div_cnt + DW'(1);
            end
         end
         default: state_nxt = PAUSED;
      endcase
   end

endmodule

// File: doc/count_tick_ctrl.md
Name: count_tick_ctrl

Overview:
- Upstream stage of the 3-bit T-flip-flop counter. Produces the single-cycle `tick` enable that drives the counter's LSB toggle input in place of the constant 1.
- Provides run/pause control and single-step control from two raw push-buttons. A free-running system clock can therefore advance the counter at a human-visible rate, or one count per button press.

Parameters:
- DIV, 50_000_000, clk cycles between ticks in RUNNING (1 Hz at 50 MHz); must be >= 2.
- DEB_CYCLES, 1_000_000, consecutive stable cycles needed to accept a button level change (20 ms at 50 MHz); must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_run  input  1  raw asynchronous button, active-high; each press toggles RUNNING/PAUSED.
- btn_step  input  1  raw asynchronous button, active-high; each press issues one tick while PAUSED.
- tick  output  1  registered one-cycle pulse; counter advances on each clk edge where tick=1.
- running  output  1  registered; 1 in RUNNING, 0 in PAUSED.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high; it is sampled on the clk rising edge.
- Reset values: tick=0, running=0, FSM=PAUSED, div_cnt=0, all synchroniser flops=0, debounced levels=0, debounce counters=0.
- Input conditioning: each button passes through a 2-flop synchroniser, then a debouncer.
- Debouncer rule: counter increments while the synced level differs from the debounced level. Counter clears to 0 whenever they are equal. When the counter reaches DEB_CYCLES, the debounced level takes the synced level and the counter clears.
- Press pulse: `press` = registered rising edge of the debounced level, exactly 1 cycle wide. Release edges generate nothing.
- Press latency: raw rising edge to press pulse = 2 (sync) + DEB_CYCLES + 1 cycles.
- Glitch rule: a glitch shorter than DEB_CYCLES cycles produces no press.
- FSM has 2 states: PAUSED, RUNNING.
- PAUSED + run_press -> RUNNING, div_cnt := 0.
- PAUSED + step_press (no run_press that cycle) -> stay PAUSED; tick=1 on the next cycle for exactly 1 cycle.
- PAUSED + run_press and step_press in the same cycle: run wins; step is discarded and no tick is issued.
- RUNNING + run_press -> PAUSED, div_cnt := 0. A tick already registered for that cycle still appears; no further ticks follow.
- RUNNING: step_press is ignored.
- RUNNING prescaler: div_cnt increments each cycle, width $clog2(DIV). When div_cnt == DIV-1, div_cnt wraps to 0 and tick is asserted on the following cycle.
- First tick after entering RUNNING appears DIV+1 cycles after the run_press cycle. Tick period in RUNNING is exactly DIV cycles.
- PAUSED: div_cnt held at 0, with no drift.
- `running` is updated in the same cycle as the FSM state register.
- tick never lasts more than 1 cycle. At most one tick is issued per step press.
- Reset mid-operation: reset asserted in any state, including mid-debounce or the tick cycle, returns all values to the reset values on the next edge. tick is 0 in the cycle after reset.
- Held button: holding a button produces exactly one press. The next press requires release, debounced for DEB_CYCLES, then press again.

Decomposition:
- Shared package `count_tick_pkg`:
  - typedef for the FSM state enum, {PAUSED, RUNNING}.
  - localparam for synchroniser depth = 2.
  - function computing the div_cnt width from DIV.
- Sub-module `btn_debounce` (parameter DEB_CYCLES):
  - ports: clk, reset, btn_raw, level, press.
  - contains the synchroniser, stability counter and edge detector.
  - instantiated twice.
- Top module holds the FSM and the prescaler.

Test Plan (DIV=5, DEB_CYCLES=4):
- Reset held 3 cycles, buttons idle -> tick=0 and running=0 for 50 cycles after release.
- btn_run high 20 cycles -> single run_press 7 cycles after the raw edge; running=1 next cycle. tick pulses at run_press+6, +11, +16 (period 5, 1 cycle wide). Nothing further happens while the button stays held.
- While PAUSED, btn_step glitch high 2 cycles -> no tick. Then btn_step high 10 cycles -> exactly one tick, 8 cycles after the raw edge; running stays 0.
- While RUNNING, btn_step pressed -> tick spacing stays exactly 5 and no extra tick appears. Second btn_run press -> running=0 and no ticks for 40 cycles.
- btn_run and btn_step raw edges in the same cycle while PAUSED -> running=1 and no step tick; first tick DIV+1 cycles after the press pulse.
- reset asserted the cycle tick=1 in RUNNING, and again mid-debounce -> the next edge gives running=0, tick=0, and the pending press is lost.
